// File: rtl/dc_vlc_pkg.sv
// dc_vlc_pkg: shared state encoding, widths and default sizing
// for the DC VLC slice sequencer.
package dc_vlc_pkg;

    localparam int COEFF_W         = 32;
    localparam int LEN_W           = 32;
    localparam int DEF_MAX_BLOCKS  = 32;
    localparam int DEF_ENC_LATENCY = 6;
    localparam int DEF_RST_CYCLES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        ISSUE,
        DRAIN,
        FIN
    } seq_state_t;

endpackage

// File: rtl/dc_vlc_coeff_buf.sv
// dc_vlc_coeff_buf: per-slice coefficient store with synchronous
// write and a registered read port that reads zero when idle.
module dc_vlc_coeff_buf
    import dc_vlc_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_BLOCKS,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [COEFF_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [COEFF_W-1:0] o_rd_data
);

    logic [COEFF_W-1:0] r_mem [DEPTH];
    logic [COEFF_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register is the encoder input, so it idles at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dc_vlc_slice_sequencer.sv
// dc_vlc_slice_sequencer: buffers a slice, resets and feeds the DC VLC
// encoder back-to-back, tags codewords. DC_VLC_SLICE_BITS_EN adds slice_bits.
module dc_vlc_slice_sequencer
    import dc_vlc_pkg::*;
#(
    parameter int MAX_BLOCKS  = DEF_MAX_BLOCKS,
    parameter int ENC_LATENCY = DEF_ENC_LATENCY,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    localparam int CW = $clog2(MAX_BLOCKS + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CW-1:0]      num_blocks,
    output logic               busy,
    output logic               done,
    input  logic [COEFF_W-1:0] in_dc_coeff,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               enc_rst_n,
    output logic [COEFF_W-1:0] enc_dc_coeff,
    input  logic [COEFF_W-1:0] enc_sum,
    input  logic [LEN_W-1:0]   enc_len,
    output logic [COEFF_W-1:0] out_sum,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_valid,
    output logic               out_last,
    output logic [LEN_W-1:0]   slice_bits
);

    localparam int AW    = $clog2(MAX_BLOCKS);
    localparam int RCW   = $clog2(RST_CYCLES + 1);
    localparam int L     = ENC_LATENCY;

    seq_state_t r_state;
    logic [CW-1:0]  r_n;
    logic [CW-1:0]  r_wr_cnt;
    logic [CW-1:0]  r_iss_cnt;
    logic [RCW-1:0] r_clr_cnt;
    logic r_busy;
    logic r_done;
    logic r_in_ready;
    logic r_enc_rst_n;

    logic [L-1:0] r_vld_sr;
    logic [L-1:0] r_last_sr;
    logic               r_out_valid;
    logic               r_out_last;
    logic [COEFF_W-1:0] r_out_sum;
    logic [LEN_W-1:0]   r_out_len;

    logic [CW-1:0] w_n_clamp;
    logic w_start_acc;
    logic w_wr_fire;
    logic w_clr_entry;
    logic w_clr_done;
    logic w_iss;
    logic w_iss_more;
    logic w_iss_last;
    logic w_rd_en;

    assign w_n_clamp = (num_blocks > CW'(MAX_BLOCKS)) ?
                       CW'(MAX_BLOCKS) : num_blocks;
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_wr_fire   = r_in_ready && in_valid;
    assign w_clr_entry = w_wr_fire && (r_wr_cnt + CW'(1) == r_n);
    assign w_clr_done  = (r_state == CLEAR) &&
                         (r_clr_cnt == RCW'(RST_CYCLES - 1));
    assign w_iss       = (r_state == ISSUE);
    assign w_iss_more  = w_iss && (r_iss_cnt < r_n);
    assign w_iss_last  = w_iss && (r_iss_cnt == r_n);
    // Fetch coefficient k on the cycle before it is shown.
    assign w_rd_en     = w_clr_done || w_iss_more;

    dc_vlc_coeff_buf #(
        .DEPTH(MAX_BLOCKS)
    ) u_buf (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_we      (w_wr_fire),
        .i_wr_addr (r_wr_cnt[AW-1:0]),
        .i_wr_data (in_dc_coeff),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_iss_cnt[AW-1:0]),
        .o_rd_data (enc_dc_coeff)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_wr_cnt    <= '0;
            r_iss_cnt   <= '0;
            r_clr_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_enc_rst_n <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_enc_rst_n <= 1'b1;
                    if (w_start_acc) begin
                        r_n       <= w_n_clamp;
                        r_wr_cnt  <= '0;
                        r_iss_cnt <= '0;
                        r_busy    <= 1'b1;
                        if (w_n_clamp == '0) begin
                            r_state <= FIN;
                        end else begin
                            r_state    <= LOAD;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_wr_fire) begin
                        r_wr_cnt <= r_wr_cnt + CW'(1);
                    end
                    if (w_clr_entry) begin
                        r_state     <= CLEAR;
                        r_in_ready  <= 1'b0;
                        r_enc_rst_n <= 1'b0;
                        r_clr_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (w_clr_done) begin
                        r_state     <= ISSUE;
                        r_enc_rst_n <= 1'b1;
                        r_iss_cnt   <= CW'(1);
                    end else begin
                        r_clr_cnt <= r_clr_cnt + RCW'(1);
                    end
                end
                ISSUE: begin
                    if (w_iss_more) begin
                        r_iss_cnt <= r_iss_cnt + CW'(1);
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_last_sr[L-1]) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // One tag per issued coefficient, aligned with the encoder output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_sr    <= '0;
            r_last_sr   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sum   <= '0;
            r_out_len   <= '0;
        end else begin
            r_vld_sr    <= {r_vld_sr[L-2:0], w_iss};
            r_last_sr   <= {r_last_sr[L-2:0], w_iss_last};
            r_out_valid <= r_vld_sr[L-1];
            r_out_last  <= r_last_sr[L-1];
            if (r_vld_sr[L-1]) begin
                r_out_sum <= enc_sum;
                r_out_len <= enc_len;
            end
        end
    end

`ifdef DC_VLC_SLICE_BITS_EN
    logic [LEN_W-1:0] r_acc;
    logic [LEN_W-1:0] r_slice_bits;
    logic [LEN_W-1:0] w_acc_next;

    assign w_acc_next = r_out_valid ? (r_acc + r_out_len) : r_acc;

    // The final codeword lands in FIN, so the snapshot includes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_slice_bits <= '0;
        end else begin
            if (w_start_acc || w_clr_entry) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
            if (r_state == FIN) begin
                r_slice_bits <= w_acc_next;
            end
        end
    end

    assign slice_bits = r_slice_bits;
`else
    assign slice_bits = '0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign enc_rst_n = r_enc_rst_n;
    assign out_sum   = r_out_sum;
    assign out_len   = r_out_len;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_dc_vlc_slice_sequencer.sv
// tb_dc_vlc_slice_sequencer: directed + random slices against a stub
// encoder (latency 6, sum=coeff, len=(coeff&0xF)+1) and a queue model.
module tb_dc_vlc_slice_sequencer;

    localparam int MAXB    = 32;
    localparam int ENC_LAT = 6;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [5:0]  num_blocks;
    logic        busy;
    logic        done;
    logic [31:0] in_dc_coeff;
    logic        in_valid;
    logic        in_ready;
    logic        enc_rst_n;
    logic [31:0] enc_dc_coeff;
    logic [31:0] enc_sum;
    logic [31:0] enc_len;
    logic [31:0] out_sum;
    logic [31:0] out_len;
    logic        out_valid;
    logic        out_last;
    logic [31:0] slice_bits;

    dc_vlc_slice_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .num_blocks   (num_blocks),
        .busy         (busy),
        .done         (done),
        .in_dc_coeff  (in_dc_coeff),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enc_rst_n    (enc_rst_n),
        .enc_dc_coeff (enc_dc_coeff),
        .enc_sum      (enc_sum),
        .enc_len      (enc_len),
        .out_sum      (out_sum),
        .out_len      (out_len),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .slice_bits   (slice_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pipe [ENC_LAT];
    always @(posedge clk) begin
        if (!enc_rst_n) begin
            for (int i = 0; i < ENC_LAT; i++) pipe[i] <= 32'h0;
        end else begin
            pipe[0] <= enc_dc_coeff;
            for (int i = 1; i < ENC_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign enc_sum = pipe[ENC_LAT-1];
    assign enc_len = (pipe[ENC_LAT-1] & 32'hF) + 32'd1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int st_cyc;
    int n_done, done_cyc, n_rdy, n_rstlow, rstlow_last;
    logic [31:0] sb_at_done;
    logic [31:0] o_sum [$];
    logic [31:0] o_len [$];
    bit          o_last [$];
    int          o_cyc [$];
    logic [31:0] i_val [$];
    int          i_cyc [$];
    logic [31:0] cq [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        n_done = 0; done_cyc = -1; n_rdy = 0;
        n_rstlow = 0; rstlow_last = -1; sb_at_done = 32'hx;
        o_sum.delete(); o_len.delete(); o_last.delete(); o_cyc.delete();
        i_val.delete(); i_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            o_sum.push_back(out_sum);
            o_len.push_back(out_len);
            o_last.push_back(out_last);
            o_cyc.push_back(cyc);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            sb_at_done = slice_bits;
        end
        if (in_ready) n_rdy++;
        if (!enc_rst_n) begin
            n_rstlow++;
            rstlow_last = cyc;
        end
        if (enc_dc_coeff != 32'h0) begin
            i_val.push_back(enc_dc_coeff);
            i_cyc.push_back(cyc);
        end
    endtask

    task automatic fill_random(input int n);
        logic [31:0] v;
        cq.delete();
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            if (v == 32'h0) v = 32'h1;
            cq.push_back(v);
        end
    endtask

    task automatic begin_slice(input int n);
        num_blocks = 6'(n);
        start = 1'b1;
        st_cyc = cyc;
        tick();
        start = 1'b0;
        num_blocks = 6'($urandom);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic feed(input int gmode, output int idx);
        int budget;
        bit fire;
        idx = 0;
        budget = 0;
        while (in_ready && budget < 1000) begin
            if (gmode == 0) in_valid = 1'b1;
            else if (gmode == 1) in_valid = (budget % 2 == 0);
            else in_valid = 1'($urandom_range(0, 1));
            in_dc_coeff = (idx < cq.size()) ? cq[idx] : 32'h0;
            fire = in_valid;
            tick();
            budget++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        in_dc_coeff = 32'h0;
    endtask

    task automatic run_slice(input int n, input int gmode, input bit poke);
        int m, idx, budget;
        logic [31:0] bits;
        bit p1, p2;
        m = (n > MAXB) ? MAXB : n;
        mon_clear();
        begin_slice(n);
        feed(gmode, idx);
        chk("accepted", idx, m);
        p1 = 1'b0;
        p2 = 1'b0;
        budget = 0;
        while (!done && budget < 400) begin
            start = 1'b0;
            if (poke && !p1 && i_val.size() > 0) begin
                start = 1'b1; num_blocks = 6'd3; p1 = 1'b1;
            end else if (poke && !p2 && out_last) begin
                start = 1'b1; num_blocks = 6'd7; p2 = 1'b1;
            end
            tick();
            budget++;
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        if (poke) chk("poked_issue_fin", {p1, p2}, 2'b11);
        repeat (12) tick();
        chk("n_done", n_done, 1);
        chk("n_out", o_sum.size(), m);
        bits = 32'h0;
        for (int i = 0; i < m; i++) begin
            bits += (cq[i] & 32'hF) + 32'd1;
            if (i < o_sum.size()) begin
                chk("out_sum", o_sum[i], cq[i]);
                chk("out_len", o_len[i], (cq[i] & 32'hF) + 32'd1);
                chk("out_last", o_last[i], i == m - 1);
            end
        end
        if (m > 0) begin
            chk("rst_low_cycles", n_rstlow, 2);
            chk("n_issued", i_val.size(), m);
            if (i_val.size() == m) begin
                for (int i = 0; i < m; i++) chk("issue_val", i_val[i], cq[i]);
                chk("issue_contig", i_cyc[m-1] - i_cyc[0], m - 1);
                chk("issue_after_rst", i_cyc[0], rstlow_last + 1);
            end
            if (o_cyc.size() > 0 && i_cyc.size() > 0) begin
                chk("codeword_latency", o_cyc[0] - i_cyc[0], ENC_LAT + 1);
                chk("done_after_last", done_cyc, o_cyc[o_cyc.size()-1] + 1);
            end
        end else begin
            chk("n0_rst_low", n_rstlow, 0);
            chk("n0_ready", n_rdy, 0);
            chk("n0_issued", i_val.size(), 0);
            chk("n0_done_lat", done_cyc, st_cyc + 2);
        end
`ifdef DC_VLC_SLICE_BITS_EN
        chk("slice_bits", sb_at_done, bits);
`else
        chk("slice_bits", sb_at_done, 32'h0);
`endif
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", in_ready, 1'b0);
    endtask

    initial begin
        int idx, budget;
        reset_n = 1'b0;
        start = 1'b0;
        num_blocks = 6'd0;
        in_valid = 1'b0;
        in_dc_coeff = 32'h0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_enc_rst_n", enc_rst_n, 1'b0);
        chk("rst_enc_coeff", enc_dc_coeff, 32'h0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_len", out_len, 32'h0);
        chk("rst_slice_bits", slice_bits, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_enc_rst_n", enc_rst_n, 1'b1);

        cq = '{32'd100, 32'd98, 32'd101, 32'd101};
        run_slice(4, 0, 1'b0);

        fill_random(3);
        run_slice(3, 1, 1'b0);

        run_slice(0, 0, 1'b0);

        fill_random(40);
        run_slice(40, 2, 1'b0);

        fill_random(5);
        run_slice(5, 0, 1'b1);

        fill_random(4);
        mon_clear();
        begin_slice(4);
        feed(0, idx);
        chk("rst_case_accepted", idx, 4);
        budget = 0;
        while (o_sum.size() == 0 && budget < 100) begin
            tick();
            budget++;
        end
        chk("rst_case_first_out", o_sum.size(), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_enc_rst_n", enc_rst_n, 1'b0);
        chk("async_busy", busy, 1'b0);
        tick();
        reset_n = 1'b1;
        mon_clear();
        repeat (20) tick();
        chk("post_rst_done", n_done, 0);
        chk("post_rst_outs", o_sum.size(), 0);
        chk("post_rst_issue", i_val.size(), 0);

        fill_random(2);
        run_slice(2, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, MAXB);
            fill_random(n);
            run_slice(n, 2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
